// File: rtl/ram_client_pkg.sv
// Shared types and default widths for the RAM initiator and its response FIFO.
// Width defaults must agree with the Ram instance they drive.
package mem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } mem_state_t;

  localparam int MEM_ADDR_W = 4;
  localparam int MEM_DATA_W = 16;

  // Bits needed to hold an occupancy value from 0 to depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ram_client_if.sv
// Core-side load/store request and load-response handshake of ram_client.
// master = core (issues requests, consumes responses), slave = ram_client.
interface ram_client_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/ram_client_rsp_fifo.sv
// Small circular response FIFO; pointers wrap modulo DEPTH, storage is not reset.
// Simultaneous push and pop leaves the occupancy unchanged, including when full.
module rsp_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int W     = MEM_DATA_W
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [W-1:0]                 head
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_pop = pop && (r_count != '0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ram_client.sv
// Initiator for a single-cycle synchronous RAM: optional zero sweep after reset,
// then load/store traffic with in-order load responses through rsp_fifo.
module ram_client
  import mem_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int RSP_DEPTH  = 3,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  ram_client_if.slave       bus,
  output logic [ADDR_W-1:0] ram_ra,
  output logic [ADDR_W-1:0] ram_wa,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_result
);

  localparam int CNT_W = cnt_w(RSP_DEPTH);
  localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W + 1)'(RSP_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam mem_state_t        RST_STATE = (INIT_CLEAR != 0) ? INIT : RUN;

  mem_state_t        r_state;
  logic [ADDR_W-1:0] r_init_cnt;
  logic              r_inflight_p1;

  logic [CNT_W-1:0]  w_count;
  logic [DATA_W-1:0] w_head;
  logic [CNT_W:0]    w_occ;
  logic              w_run;
  logic              w_init;
  logic              w_accept;
  logic              w_store;
  logic              w_load;
  logic              w_rsp_valid;
  logic              w_pop;

  // Outputs are gated by reset_n so every port reads zero while reset is held.
  assign w_run  = reset_n && (r_state == RUN);
  assign w_init = reset_n && (r_state == INIT);

  // Occupancy counts the load whose data is still on ram_result; registered terms only.
  assign w_occ         = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight_p1};
  assign bus.req_ready = w_run && (w_occ < DEPTH_C);

  assign w_accept = bus.req_valid && bus.req_ready;
  assign w_store  = w_accept && bus.req_we;
  assign w_load   = w_accept && !bus.req_we;

  assign ram_we   = w_init || w_store;
  assign ram_wa   = w_init ? r_init_cnt : (w_run ? bus.req_addr : '0);
  assign ram_data = w_run ? bus.req_wdata : '0;
  assign ram_ra   = w_run ? bus.req_addr : '0;

  assign w_rsp_valid   = reset_n && (w_count != '0);
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = w_rsp_valid ? w_head : '0;
  assign w_pop         = w_rsp_valid && bus.rsp_ready;

  // p0 -> p1: accepted load address is in the RAM; its result is captured one edge later.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= RST_STATE;
      r_init_cnt    <= '0;
      r_inflight_p1 <= 1'b0;
    end else begin
      r_inflight_p1 <= w_load;
      case (r_state)
        INIT: begin
          r_init_cnt <= r_init_cnt + 1'b1;
          if (r_init_cnt == LAST_ADDR) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          r_init_cnt <= '0;
        end
      endcase
    end
  end

  // p1 -> p2: RAM result enters the response FIFO.
  rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (r_inflight_p1),
    .push_data (ram_result),
    .pop       (w_pop),
    .count     (w_count),
    .head      (w_head)
  );

endmodule

// File: tb/tb_ram_client.sv
// Directed bench for ram_client with a behavioural single-cycle synchronous RAM.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_ram_client;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  ram_ra;
  logic [3:0]  ram_wa;
  logic [15:0] ram_data;
  logic        ram_we;
  logic [15:0] ram_result;
  logic [15:0] ram_mem [16];

  int n_tests = 0;
  int n_fail  = 0;

  // Expected values for the stalled-consumer case (loads of 4..7, rsp_ready low until k=5).
  int          t4_rdy [7]  = '{1, 1, 1, 0, 0, 0, 1};
  logic [15:0] t4_dat [10] = '{16'h0, 16'h0, 16'h1104, 16'h1104, 16'h1104,
                               16'h1104, 16'h1105, 16'h1106, 16'h1107, 16'h0};
  logic [15:0] t6_pat = 16'b1110_1011_0000_0110;

  always #5 clk = ~clk;

  ram_client_if #(.ADDR_W(4), .DATA_W(16)) bus ();

  ram_client #(
    .ADDR_W     (4),
    .DATA_W     (16),
    .RSP_DEPTH  (3),
    .INIT_CLEAR (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .ram_ra     (ram_ra),
    .ram_wa     (ram_wa),
    .ram_data   (ram_data),
    .ram_we     (ram_we),
    .ram_result (ram_result)
  );

  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_wa] <= ram_data;
    ram_result <= ram_mem[ram_ra];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic store(input logic [3:0] a, input logic [15:0] d);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    smp();
    chk("fill_rdy", 32'(bus.req_ready), 32'd1);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] q[$];
    logic [15:0] held_d;
    logic        held;
    int          sent;
    int          got;
    int          maxcnt;
    logic [15:0] exp_d;

    reset_n       = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 4'h9;
    bus.req_wdata = 16'h1234;
    bus.rsp_ready = 1'b1;

    // Reset state, twice while reset is held
    for (int r = 0; r < 2; r++) begin
      smp();
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
      chk("rst_ram_we",    32'(ram_we),        32'd0);
      chk("rst_ram_wa",    32'(ram_wa),        32'd0);
      chk("rst_ram_ra",    32'(ram_ra),        32'd0);
      chk("rst_ram_data",  32'(ram_data),      32'd0);
      cyc();
    end

    // Zero sweep: 16 cycles, load of 7 held pending the whole time
    reset_n      = 1'b1;
    bus.req_we   = 1'b0;
    bus.req_addr = 4'h7;
    for (int i = 0; i < 16; i++) begin
      smp();
      chk("init_req_ready", 32'(bus.req_ready), 32'd0);
      chk("init_ram_we",    32'(ram_we),        32'd1);
      chk("init_ram_wa",    32'(ram_wa),        32'(i));
      chk("init_ram_data",  32'(ram_data),      32'd0);
      chk("init_ram_ra",    32'(ram_ra),        32'd0);
      cyc();
    end
    smp();
    chk("first_req_ready", 32'(bus.req_ready), 32'd1);
    chk("first_ram_ra",    32'(ram_ra),        32'd7);
    chk("first_ram_we",    32'(ram_we),        32'd0);
    cyc();
    bus.req_valid = 1'b0;
    smp();
    chk("ld7_n1_valid", 32'(bus.rsp_valid), 32'd0);
    cyc();
    smp();
    chk("ld7_n2_valid", 32'(bus.rsp_valid), 32'd1);
    chk("ld7_n2_data",  32'(bus.rsp_data),  32'h0000);
    cyc();
    smp();
    chk("ld7_drained", 32'(bus.rsp_valid), 32'd0);
    cyc();

    // Store 0xBEEF to 3 in cycle N, load 3 in N+1, response in N+3
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 4'h3;
    bus.req_wdata = 16'hBEEF;
    smp();
    chk("st_req_ready", 32'(bus.req_ready), 32'd1);
    chk("st_ram_we",    32'(ram_we),        32'd1);
    chk("st_ram_wa",    32'(ram_wa),        32'd3);
    chk("st_ram_data",  32'(ram_data),      32'hBEEF);
    cyc();
    bus.req_we = 1'b0;
    smp();
    chk("raw_req_ready", 32'(bus.req_ready), 32'd1);
    chk("raw_ram_ra",    32'(ram_ra),        32'd3);
    chk("raw_ram_we",    32'(ram_we),        32'd0);
    cyc();
    bus.req_valid = 1'b0;
    smp();
    chk("raw_n2_valid", 32'(bus.rsp_valid), 32'd0);
    cyc();
    smp();
    chk("raw_n3_valid", 32'(bus.rsp_valid), 32'd1);
    chk("raw_n3_data",  32'(bus.rsp_data),  32'hBEEF);
    cyc();

    for (int i = 0; i < 16; i++) store(4'(i), 16'(32'h1100 + i));
    bus.req_valid = 1'b0;

    // Back-to-back loads 0..3 with the consumer always ready
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 4'(k);
      end else begin
        bus.req_valid = 1'b0;
      end
      smp();
      if (k < 4) chk("b2b_req_ready", 32'(bus.req_ready), 32'd1);
      if (k >= 2 && k < 6) begin
        chk("b2b_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("b2b_rsp_data",  32'(bus.rsp_data),  32'h1100 + 32'(k - 2));
      end
      if (k == 6) chk("b2b_idle", 32'(bus.rsp_valid), 32'd0);
      cyc();
    end

    // Four loads against a stalled consumer, then drain
    for (int k = 0; k < 10; k++) begin
      bus.rsp_ready = (k >= 5);
      if (k < 3) begin
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 4'(4 + k);
      end else if (k < 7) begin
        bus.req_valid = 1'b1;
        bus.req_addr  = 4'h7;
      end else begin
        bus.req_valid = 1'b0;
      end
      smp();
      if (k < 7) chk("bp_req_ready", 32'(bus.req_ready), 32'(t4_rdy[k]));
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'(t4_dat[k] != 16'h0));
      chk("bp_rsp_data",  32'(bus.rsp_data),  32'(t4_dat[k]));
      if (k == 4 || k == 5) chk("bp_fifo_count", 32'(dut.w_count), 32'd3);
      cyc();
    end

    // Reset pulse with two entries queued and one load in flight
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 4'(8 + k);
      smp();
      chk("pre_rst_req_ready", 32'(bus.req_ready), 32'd1);
      if (k == 2) begin
        chk("pre_rst_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("pre_rst_rsp_data",  32'(bus.rsp_data),  32'h1108);
      end
      cyc();
    end
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    smp();
    chk("mid_rst_fifo_count", 32'(dut.w_count),     32'd2);
    chk("mid_rst_inflight",   32'(dut.r_inflight_p1), 32'd1);
    chk("mid_rst_rsp_valid",  32'(bus.rsp_valid),   32'd0);
    chk("mid_rst_req_ready",  32'(bus.req_ready),   32'd0);
    chk("mid_rst_ram_we",     32'(ram_we),          32'd0);
    cyc();
    reset_n       = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      smp();
      chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      if (i < 16) begin
        chk("reinit_ram_wa", 32'(ram_wa), 32'(i));
        chk("reinit_ram_we", 32'(ram_we), 32'd1);
      end
      if (i == 0) chk("post_rst_fifo_count", 32'(dut.w_count), 32'd0);
      cyc();
    end

    // Ten loads with an irregular consumer: order, hold and full occupancy
    for (int i = 0; i < 10; i++) store(4'(i), 16'(32'h2200 + i));
    sent   = 0;
    got    = 0;
    maxcnt = 0;
    held   = 1'b0;
    held_d = '0;
    for (int c = 0; c < 200 && got < 10; c++) begin
      bus.rsp_ready = t6_pat[c % 16];
      if (sent < 10) begin
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 4'(sent);
      end else begin
        bus.req_valid = 1'b0;
      end
      smp();
      if (held) chk("wrap_hold", 32'(bus.rsp_data), 32'(held_d));
      if (int'(dut.w_count) > maxcnt) maxcnt = int'(dut.w_count);
      if (bus.req_valid && bus.req_ready) begin
        q.push_back(16'(32'h2200 + sent));
        sent++;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        exp_d = (q.size() != 0) ? q.pop_front() : 16'hDEAD;
        chk("wrap_order", 32'(bus.rsp_data), 32'(exp_d));
        got++;
      end
      if (bus.rsp_valid && !bus.rsp_ready) begin
        held   = 1'b1;
        held_d = bus.rsp_data;
      end else begin
        held = 1'b0;
      end
      cyc();
    end
    chk("wrap_rsp_count", 32'(got),      32'd10);
    chk("wrap_q_empty",   32'(q.size()), 32'd0);
    chk("wrap_max_count", 32'(maxcnt),   32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_client.md
# ram_client

Initiator-side controller for the single-cycle synchronous `Ram` block. It accepts load/store requests from the core over a valid/ready port and drives the RAM's read and write ports. It absorbs the RAM's one-cycle read latency and returns load data in order through a small response FIFO with backpressure. After every reset it can optionally sweep the RAM to zero before accepting traffic.

## Interface
Parameters:
- `ADDR_W`, 4: RAM address width; must match the RAM's `addr_size`.
- `DATA_W`, 16: data width; must match the RAM's `cell_size`.
- `RSP_DEPTH`, 3: response FIFO depth; minimum 2. Depth 3 sustains one read per cycle while `rsp_ready` stays high.
- `INIT_CLEAR`, 1: when 1, zero-fill all `2**ADDR_W` words after reset.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this cycle when high together with `req_valid`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in ADDR_W: word address.
- `req_wdata` in DATA_W: store data.
- `rsp_valid` out 1: load data available.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_data` out DATA_W: load data, in request order.
- `ram_ra` out ADDR_W: to RAM `ra`.
- `ram_wa` out ADDR_W: to RAM `wa`.
- `ram_data` out DATA_W: to RAM `data`.
- `ram_we` out 1: to RAM `we`.
- `ram_result` in DATA_W: from RAM `result`.

## Operation
- FSM with two states, `INIT` and `RUN`. Reset enters `INIT` when `INIT_CLEAR`=1, otherwise `RUN`.
- `INIT` state:
  - Outputs: `ram_we`=1, `ram_wa`=`init_cnt`, `ram_data`=0, `req_ready`=0.
  - `init_cnt` counts from 0 to `2**ADDR_W-1`, one word per cycle.
  - After the write of the last address, go to `RUN`. `INIT` lasts exactly `2**ADDR_W` cycles.
- `RUN` state:
  - `req_ready` = (`fifo_count` + `inflight`) < `RSP_DEPTH`. Only registered values feed this term, so there is no path from `rsp_ready` or `req_valid`. Stores stall under the same condition, which keeps the handshake payload-independent.
  - Accepted store: in the same cycle, `ram_we`=1, `ram_wa`=`req_addr`, `ram_data`=`req_wdata`. No response is produced.
  - Accepted load: in the same cycle, `ram_ra`=`req_addr`, and `inflight` is set for the next cycle.
  - With `inflight`=1, the cycle's `ram_result` is pushed into the FIFO at the clock edge that ends that cycle.
- `ram_ra` is `req_addr` in `RUN` and 0 in `INIT`.
- `ram_we` is 0 unless the state is `INIT` or a store is accepted in `RUN`.
- Response side: `rsp_valid` = `fifo_count`≠0 and `rsp_data` = FIFO head. A pop happens on `rsp_valid && rsp_ready`.
- Push and pop in the same cycle: `fifo_count` is unchanged. This is legal even with the FIFO full.
- FIFO read and write pointers wrap modulo `RSP_DEPTH`. The FIFO never overflows because of the accept rule.
- Ordering: a store accepted in cycle N followed by a load to the same address in cycle N+1 returns the new data. The RAM writes at the edge ending cycle N.
- Reset asserted mid-operation:
  - At the next edge, the FIFO empties, `inflight` clears and `init_cnt` returns to 0.
  - A RAM result belonging to a pre-reset load is discarded.
  - If `INIT_CLEAR`=1, `INIT` restarts from address 0.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `ram_we`=0, `ram_wa`=0, `ram_ra`=0, `ram_data`=0. All of these hold while `reset_n`=0.
- Load latency: accepted in cycle N, `rsp_valid` high in cycle N+2 at the earliest.
- Throughput: one request per cycle with `RSP_DEPTH`≥3 and `rsp_ready` held high.
- Store latency: the RAM is updated at the edge ending the accept cycle.
- First accept after reset release: cycle `2**ADDR_W` if `INIT_CLEAR`=1, otherwise cycle 0.
- `rsp_data` stays stable while `rsp_valid`=1 and `rsp_ready`=0.

## Structure
- Package `mem_pkg` holds:
  - `typedef enum logic {INIT, RUN} mem_state_t`;
  - default width constants `MEM_ADDR_W`=4 and `MEM_DATA_W`=16, shared with the `Ram` instance.
- Sub-module `rsp_fifo`:
  - parameters `DEPTH` and `W`;
  - synchronous, active-low synchronous reset;
  - outputs `count` and head data.
- The top level holds the FSM, `init_cnt`, `inflight` and the RAM port muxing.

## Test plan
Bench: instantiate the real `Ram` with `ADDR_W`=4, `DATA_W`=16, `INIT_CLEAR`=1.
- Reset, then hold `req_valid`=1 → `req_ready`=0 for exactly 16 cycles with `ram_wa` 0..15 and `ram_data`=0. A load of address 7 after that returns 0x0000.
- Store 0xBEEF to address 3 in cycle N, load address 3 in cycle N+1 → `rsp_data`=0xBEEF with `rsp_valid` high in cycle N+3.
- Back-to-back loads of addresses 0,1,2,3 with `rsp_ready`=1 → `req_ready` stays 1 and responses come in order on four consecutive cycles.
- Four loads with `rsp_ready`=0 → `req_ready` drops after the 3rd accept. `fifo_count`=3 and `rsp_data` is held stable. Raising `rsp_ready` drains 3 then 4 in order.
- `reset_n` pulsed low for one cycle while a load is in flight and the FIFO holds 2 entries → `rsp_valid`=0 the next cycle, no stale response ever appears, and `INIT` restarts at address 0.
- Simultaneous push and pop with the FIFO full → count stays 3, no data is lost and the wrap-around order is preserved across 10 loads.
